// File: rtl/pattern_rotator_sequencer.sv
// rtl/pattern_rotator_sequencer.sv - prescaled rotate/bounce/hold pattern sequencer
//
// Latches a W-bit pattern and steps its rotation amount once per prescaled tick.
// The tick is a clock enable derived from a DIV = CLK_HZ/STEP_HZ prescaler.
//
// Ports:
//   i_clk      system clock
//   i_reset    asynchronous, active-high reset
//   i_dat_in   pattern to latch
//   i_load     1-cycle strobe: latch i_dat_in and restart the sequence
//   i_run      1 = prescaler counts and steps occur, 0 = frozen
//   i_mode     00 rot-left, 01 rot-right, 10 bounce, 11 hold
//   o_dat_out  registered rotated pattern
//   o_amt      current rotation amount
//   o_dir      0 = left/up, 1 = right/down
//   o_tick     1-cycle pulse on each step edge
module pattern_rotator_sequencer #(
    parameter int W       = 8,
    parameter int CLK_HZ  = 100000000,
    parameter int STEP_HZ = 1
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [W-1:0]         i_dat_in,
    input  logic                 i_load,
    input  logic                 i_run,
    input  logic [1:0]           i_mode,
    output logic [W-1:0]         o_dat_out,
    output logic [$clog2(W)-1:0] o_amt,
    output logic                 o_dir,
    output logic                 o_tick
);
    localparam int AW  = $clog2(W);
    localparam int DIV = CLK_HZ / STEP_HZ;
    localparam int CW  = $clog2(DIV);

    localparam logic [AW-1:0] AMT_MAX  = AW'(W - 1);
    localparam logic [AW-1:0] AMT_TURN = AW'(W - 2);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DIV - 1);

    typedef enum logic [1:0] {
        MODE_ROTL   = 2'b00,
        MODE_ROTR   = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_t;

    logic [W-1:0]  r_pat;
    logic [W-1:0]  r_dat_out;
    logic [AW-1:0] r_amt;
    logic          r_dir;
    logic          r_tick;
    logic [CW-1:0] r_cnt;

    mode_t         w_mode;
    logic          w_wrap;
    logic          w_step;
    logic [AW-1:0] w_amt_next;
    logic          w_dir_next;
    logic [W-1:0]  w_rot;

    // Rotations via a doubled copy of the pattern so the wrapped bits fall into place.
    function automatic logic [W-1:0] f_rotl(input logic [W-1:0] p, input logic [AW-1:0] a);
        logic [2*W-1:0] t;
        t = {p, p} << a;
        return t[2*W-1:W];
    endfunction

    function automatic logic [W-1:0] f_rotr(input logic [W-1:0] p, input logic [AW-1:0] a);
        logic [2*W-1:0] t;
        t = {p, p} >> a;
        return t[W-1:0];
    endfunction

    always_comb begin
        w_mode     = mode_t'(i_mode);
        w_wrap     = (r_cnt == CNT_MAX);
        // A load in the wrap cycle swallows the step and its tick.
        w_step     = i_run && w_wrap && !i_load;
        w_amt_next = r_amt;
        w_dir_next = r_dir;
        case (w_mode)
            MODE_ROTL: begin
                w_amt_next = r_amt + AW'(1);
                w_dir_next = 1'b0;
            end
            MODE_ROTR: begin
                w_amt_next = r_amt + AW'(1);
                w_dir_next = 1'b1;
            end
            MODE_BOUNCE: begin
                // Turn around at the endpoints without dwelling there.
                if (!r_dir) begin
                    if (r_amt == AMT_MAX) begin
                        w_amt_next = AMT_TURN;
                        w_dir_next = 1'b1;
                    end else begin
                        w_amt_next = r_amt + AW'(1);
                    end
                end else begin
                    if (r_amt == '0) begin
                        w_amt_next = AW'(1);
                        w_dir_next = 1'b0;
                    end else begin
                        w_amt_next = r_amt - AW'(1);
                    end
                end
            end
            default: begin
                w_amt_next = r_amt;
                w_dir_next = r_dir;
            end
        endcase
        w_rot = (w_mode == MODE_ROTR) ? f_rotr(r_pat, w_amt_next) : f_rotl(r_pat, w_amt_next);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_pat     <= '0;
            r_dat_out <= '0;
            r_amt     <= '0;
            r_dir     <= 1'b0;
            r_tick    <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_tick <= w_step;
            if (i_load) begin
                r_cnt     <= '0;
                r_pat     <= i_dat_in;
                r_amt     <= '0;
                r_dir     <= (w_mode == MODE_ROTR);
                r_dat_out <= i_dat_in;
            end else if (!i_run) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= w_wrap ? '0 : r_cnt + CW'(1);
                // Hold mode still ticks but must not recompute dat_out from amt.
                if (w_wrap && w_mode != MODE_HOLD) begin
                    r_amt     <= w_amt_next;
                    r_dir     <= w_dir_next;
                    r_dat_out <= w_rot;
                end
            end
        end
    end

    assign o_dat_out = r_dat_out;
    assign o_amt     = r_amt;
    assign o_dir     = r_dir;
    assign o_tick    = r_tick;
endmodule

// File: tb/tb_pattern_rotator_sequencer.sv
// tb/tb_pattern_rotator_sequencer.sv - randomized bench for pattern_rotator_sequencer
module tb_pattern_rotator_sequencer;
    localparam int W   = 8;
    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       load;
    logic       run;
    logic [7:0] din;
    logic [1:0] mode;

    logic [7:0] dout;
    logic [2:0] amt;
    logic       dir;
    logic       tick;

    logic [1:0] dout2;
    logic [0:0] amt2;
    logic       dir2;
    logic       tick2;

    always #5 clk = ~clk;

    pattern_rotator_sequencer #(.W(8), .CLK_HZ(4), .STEP_HZ(1)) dut (
        .i_clk(clk), .i_reset(reset), .i_dat_in(din), .i_load(load), .i_run(run),
        .i_mode(mode), .o_dat_out(dout), .o_amt(amt), .o_dir(dir), .o_tick(tick)
    );

    pattern_rotator_sequencer #(.W(2), .CLK_HZ(4), .STEP_HZ(1)) dut2 (
        .i_clk(clk), .i_reset(reset), .i_dat_in(din[1:0]), .i_load(load), .i_run(run),
        .i_mode(mode), .o_dat_out(dout2), .o_amt(amt2), .o_dir(dir2), .o_tick(tick2)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: pattern, amount, direction, visible output and run-cycle phase.
    logic [7:0] m_pat;
    logic [7:0] m_out;
    int         m_amt;
    bit         m_dir;
    bit         m_tick;
    int         m_phase;

    function automatic logic [7:0] ref_rot(input logic [7:0] p, input int a, input bit right);
        logic [7:0] r;
        for (int i = 0; i < W; i++) begin
            if (right) r[i] = p[(i + a) % W];
            else       r[(i + a) % W] = p[i];
        end
        return r;
    endfunction

    task automatic model_reset();
        m_pat = '0; m_out = '0; m_amt = 0; m_dir = 0; m_tick = 0; m_phase = 0;
    endtask

    task automatic model_edge();
        m_tick = 0;
        if (load) begin
            m_pat = din; m_out = din; m_amt = 0; m_dir = (mode == 2'b01); m_phase = 0;
        end else if (!run) begin
            m_phase = 0;
        end else begin
            m_phase++;
            if (m_phase == DIV) begin
                m_phase = 0;
                m_tick  = 1;
                case (mode)
                    2'b00: begin m_amt = (m_amt + 1) % W; m_dir = 0; m_out = ref_rot(m_pat, m_amt, 0); end
                    2'b01: begin m_amt = (m_amt + 1) % W; m_dir = 1; m_out = ref_rot(m_pat, m_amt, 1); end
                    2'b10: begin
                        if (!m_dir) begin
                            if (m_amt == W - 1) begin m_dir = 1; m_amt = W - 2; end
                            else m_amt = m_amt + 1;
                        end else begin
                            if (m_amt == 0) begin m_dir = 0; m_amt = 1; end
                            else m_amt = m_amt - 1;
                        end
                        m_out = ref_rot(m_pat, m_amt, 0);
                    end
                    default: ;
                endcase
            end
        end
    endtask

    task automatic check_all();
        chk("dat_out", dout, m_out);
        chk("amt", amt, m_amt);
        chk("dir", dir, m_dir);
        chk("tick", tick, m_tick);
    endtask

    task automatic cyc();
        @(posedge clk);
        if (reset) model_reset();
        else model_edge();
        #1;
        check_all();
    endtask

    task automatic async_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; run = 1'b0; din = '0; mode = 2'b00;
        #1;
        model_reset();
        check_all();
        cyc(); cyc();
        reset = 1'b0;
        run = 1'b1;
        repeat (6) cyc();

        // Rotate left with wrap.
        din = 8'h01; mode = 2'b00; load = 1'b1; cyc(); load = 1'b0;
        chk("rotl_load", dout, 8'h01);
        repeat (28) cyc();
        chk("rotl_at7", dout, 8'h80);
        repeat (4) cyc();
        chk("rotl_wrap_out", dout, 8'h01);
        chk("rotl_wrap_amt", amt, 0);
        chk("rotl_wrap_tick", tick, 1);

        // Mid-run asynchronous reset, then idle with run low.
        repeat (2) cyc();
        async_reset();
        run = 1'b0;
        repeat (6) cyc();
        run = 1'b1;

        // Rotate right.
        din = 8'h01; mode = 2'b01; load = 1'b1; cyc(); load = 1'b0;
        chk("rotr_dir", dir, 1);
        repeat (4) cyc();
        chk("rotr_first", dout, 8'h80);
        repeat (32) cyc();

        // Bounce, alongside a W=2 instance loaded with 2'b01.
        din = 8'h81; mode = 2'b10; load = 1'b1; cyc(); load = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            repeat (4) cyc();
            chk("w2_amt", amt2, k % 2);
            chk("w2_out", dout2, (k % 2) ? 2'b10 : 2'b01);
            if (k == 7) begin
                chk("bounce_c0", dout, 8'hC0);
                chk("bounce_amt7", amt, 7);
            end
            if (k == 15) begin
                chk("bounce_turn_amt", amt, 1);
                chk("bounce_turn_dir", dir, 0);
            end
        end

        // Load collides with the wrap cycle.
        din = 8'h3C; mode = 2'b00; load = 1'b1; cyc(); load = 1'b0;
        repeat (3) cyc();
        din = 8'h5A; load = 1'b1; cyc(); load = 1'b0;
        chk("collide_tick", tick, 0);
        chk("collide_out", dout, 8'h5A);
        chk("collide_amt", amt, 0);
        repeat (3) cyc();
        chk("collide_no_early", tick, 0);
        cyc();
        chk("collide_next_tick", tick, 1);

        // Pause, switch to hold, resume.
        repeat (5) cyc();
        run = 1'b0;
        repeat (10) cyc();
        mode = 2'b11;
        run = 1'b1;
        repeat (3) cyc();
        chk("hold_no_early", tick, 0);
        cyc();
        chk("hold_tick", tick, 1);
        repeat (12) cyc();

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            load = ($urandom_range(0, 19) == 0);
            run  = ($urandom_range(0, 7) != 0);
            din  = 8'($urandom);
            if ($urandom_range(0, 29) == 0) mode = 2'($urandom);
            if ($urandom_range(0, 299) == 0) async_reset();
            else cyc();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
